// File: rtl/serial_link_pkg.sv
// serial_link_pkg: shared word defaults and scheduler state encodings
package serial_link_pkg;
  localparam int WORD_BITS_DEF = 10;
  localparam logic [9:0] IDLE_WORD_DEF = 10'b1101010100;
  localparam logic [9:0] TRAIN_WORD_DEF = 10'b1111100000;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_TRAIN = 2'd1;
  localparam logic [1:0] S_RUN = 2'd2;
endpackage

// File: rtl/word_fifo2.sv
// word_fifo2: two-deep synchronous FIFO with flush and registered full/empty
module word_fifo2 #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2];
  logic wp, rp;
  logic [1:0] count, nxt;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rdata = mem[rp];
  // next occupancy, so the flags can be registered alongside the count
  always_comb nxt = count + {1'b0, do_push} - {1'b0, do_pop};
  // storage, pointers and flags; flush drops everything including a same-cycle push
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp <= 1'b0;
      rp <= 1'b0;
      count <= 2'd0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_push) begin
        mem[wp] <= wdata;
        wp <= ~wp;
      end
      if (do_pop) rp <= ~rp;
      count <= nxt;
      full <= nxt == 2'd2;
      empty <= nxt == 2'd0;
    end
  end
endmodule

// File: rtl/serial_word_scheduler.sv
// serial_word_scheduler: picks one word per serializer period from training, stream or idle
module serial_word_scheduler
  import serial_link_pkg::*;
#(
  parameter int WORD_BITS = WORD_BITS_DEF,
  parameter logic [WORD_BITS-1:0] IDLE_WORD = WORD_BITS'(IDLE_WORD_DEF),
  parameter logic [WORD_BITS-1:0] TRAIN_WORD = WORD_BITS'(TRAIN_WORD_DEF),
  parameter int TRAIN_WORDS = 16,
  parameter int UFLOW_W = 16
) (
  input  logic                 ref_clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 train_req,
  input  logic [WORD_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WORD_BITS-1:0] word_out,
  output logic                 word_load,
  output logic [3:0]           bit_phase,
  output logic                 training,
  output logic [UFLOW_W-1:0]   underflow_cnt
);
  localparam int TW = $clog2(TRAIN_WORDS + 1);
  logic [1:0] state;
  logic [TW-1:0] tcnt;
  logic b, run_slot, push, pop, flush, full, empty;
  logic [WORD_BITS-1:0] rd_data;
  assign b = bit_phase == 4'(WORD_BITS - 1);
  assign word_load = b;
  assign training = state == S_TRAIN;
  assign in_ready = (state != S_IDLE) && !full;
  assign push = in_valid && in_ready;
  assign run_slot = b && enable && ((state == S_RUN && !train_req) || (state == S_TRAIN && tcnt == TW'(TRAIN_WORDS)));
  assign pop = run_slot && !empty;
  assign flush = (state == S_IDLE) || (b && !enable);
  word_fifo2 #(.W(WORD_BITS)) u_fifo (
    .clk(ref_clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .flush(flush),
    .wdata(in_data),
    .rdata(rd_data),
    .full(full),
    .empty(empty)
  );
  // serializer bit position, wrapping once per word
  always_ff @(posedge ref_clk) begin
    if (rst) bit_phase <= 4'd0;
    else bit_phase <= b ? 4'd0 : bit_phase + 4'd1;
  end
  // mode and outgoing word change only at the word boundary; counter tracks training words sent
  always_ff @(posedge ref_clk) begin
    if (rst) begin
      state <= S_IDLE;
      tcnt <= '0;
      word_out <= IDLE_WORD;
    end else if (b) begin
      if (!enable) begin
        state <= S_IDLE;
        word_out <= IDLE_WORD;
      end else if (state == S_IDLE || (state == S_RUN && train_req)) begin
        state <= S_TRAIN;
        tcnt <= TW'(1);
        word_out <= TRAIN_WORD;
      end else if (run_slot) begin
        state <= S_RUN;
        word_out <= empty ? IDLE_WORD : rd_data;
      end else begin
        tcnt <= tcnt + 1'b1;
        word_out <= TRAIN_WORD;
      end
    end
  end
  // saturating count of run slots that found no upstream word
  always_ff @(posedge ref_clk) begin
    if (rst) underflow_cnt <= '0;
    else if (run_slot && empty && underflow_cnt != '1) underflow_cnt <= underflow_cnt + 1'b1;
  end
endmodule

// File: tb/tb_serial_word_scheduler.sv
// tb_serial_word_scheduler: randomized stimulus checked against a queue-based link model
module tb_serial_word_scheduler;
  localparam int WB = 10;
  localparam int TWN = 16;
  localparam int IW = 'h354;
  localparam int TWD = 'h3E0;
  typedef enum int {M_IDLE, M_TRAIN, M_RUN} mode_t;
  logic ref_clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic train_req = 1'b0;
  logic in_valid = 1'b0;
  logic [9:0] in_data = '0;
  logic in_ready, word_load, training;
  logic [9:0] word_out;
  logic [3:0] bit_phase;
  logic [15:0] underflow_cnt;
  int n_tests = 0;
  int n_fail = 0;
  int p_valid = 0;
  bit m_known = 0;
  int m_phase, m_word, m_left, m_uf;
  mode_t m_mode;
  int m_q[$];

  serial_word_scheduler dut (
    .ref_clk(ref_clk),
    .rst(rst),
    .enable(enable),
    .train_req(train_req),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .word_out(word_out),
    .word_load(word_load),
    .bit_phase(bit_phase),
    .training(training),
    .underflow_cnt(underflow_cnt)
  );

  always #5 ref_clk = ~ref_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h required=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare();
    if (!m_known) return;
    check("word_out", word_out, m_word);
    check("bit_phase", bit_phase, m_phase);
    check("word_load", word_load, m_phase == WB - 1);
    check("in_ready", in_ready, m_mode != M_IDLE && m_q.size() < 2);
    check("training", training, m_mode == M_TRAIN);
    check("underflow_cnt", underflow_cnt, m_uf);
  endtask

  task automatic model_edge();
    bit push;
    push = in_valid && m_mode != M_IDLE && m_q.size() < 2;
    if (rst) begin
      m_known = 1;
      m_phase = 0;
      m_mode = M_IDLE;
      m_word = IW;
      m_left = 0;
      m_uf = 0;
      m_q.delete();
      return;
    end
    if (!m_known) return;
    if (m_phase == WB - 1) begin
      if (!enable) begin
        m_mode = M_IDLE;
        m_word = IW;
        m_q.delete();
        push = 0;
      end else if (m_mode == M_IDLE || (m_mode == M_RUN && train_req)) begin
        m_mode = M_TRAIN;
        m_word = TWD;
        m_left = TWN - 1;
      end else if (m_mode == M_TRAIN && m_left > 0) begin
        m_word = TWD;
        m_left--;
      end else begin
        m_mode = M_RUN;
        if (m_q.size() > 0) m_word = m_q.pop_front();
        else begin
          m_word = IW;
          if (m_uf < 65535) m_uf++;
        end
      end
    end
    if (push) m_q.push_back(int'(in_data));
    m_phase = (m_phase + 1) % WB;
  endtask

  task automatic step();
    in_valid = $urandom_range(99) < p_valid;
    in_data = 10'($urandom_range(1023));
    #4;
    compare();
    model_edge();
    @(posedge ref_clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_phase(input int ph);
    int k = 0;
    while (m_phase != ph && k < 2 * WB) begin
      step();
      k++;
    end
    check("phase_reach", bit_phase, ph);
  endtask

  initial begin
    @(posedge ref_clk);
    #1;
    run(3);
    rst = 1'b0;
    check("reset_word", word_out, IW);
    check("reset_ready", in_ready, 0);
    run(3 * WB);
    enable = 1'b1;
    p_valid = 100;
    run(WB * 25);
    check("stream_uflow", underflow_cnt, 0);
    p_valid = 0;
    run(WB * 5);
    p_valid = 100;
    run(WB * 4);
    p_valid = 60;
    run(WB * 30);
    p_valid = 100;
    wait_phase(4);
    enable = 1'b0;
    run(WB * 2);
    check("idle_ready", in_ready, 0);
    enable = 1'b1;
    run(WB * 20);
    train_req = 1'b1;
    run(WB);
    train_req = 1'b0;
    run(WB * 20);
    wait_phase(5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_word", word_out, IW);
    check("midrst_phase", bit_phase, 0);
    run(WB * 22);
    for (int i = 0; i < 40; i++) begin
      enable = $urandom_range(99) < 90;
      train_req = $urandom_range(99) < 5;
      p_valid = $urandom_range(100);
      rst = $urandom_range(99) < 3;
      step();
      rst = 1'b0;
      run($urandom_range(40, 5));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
